// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - converts the FIFO enable/empty read port into a valid/ready stream
// A 3-entry ring buffer absorbs the one-cycle read latency so the stream runs at full rate.
module fifo_rd_stream #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fifo_empty,
   output logic             fifo_en,
   input  logic [WIDTH-1:0] fifo_dout,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic [1:0]       level
);

   logic [1:0]       occ_q, occ_d;
   logic             infl_q;
   logic [1:0]       wp_q, wp_d;
   logic [1:0]       rp_q, rp_d;
   logic [WIDTH-1:0] buf_q [3];
   logic [2:0]       credit;
   logic             pop;

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Words buffered plus the read in flight; m_ready never enters this path.
   assign credit  = {1'b0, occ_q} + {2'b00, infl_q};
   assign fifo_en = rst & ~fifo_empty & (credit < 3'd3);
   assign m_valid = (occ_q != 2'd0);
   assign pop     = m_valid & m_ready;
   assign level   = occ_q;

   always_comb begin
      occ_d = occ_q + {1'b0, infl_q} - {1'b0, pop};
      wp_d  = infl_q ? ptr_inc(wp_q) : wp_q;
      rp_d  = pop    ? ptr_inc(rp_q) : rp_q;
   end

   always_comb begin
      m_data = '0;
      case (rp_q)
         2'd0:    m_data = buf_q[0];
         2'd1:    m_data = buf_q[1];
         default: m_data = buf_q[2];
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         occ_q  <= 2'd0;
         infl_q <= 1'b0;
         wp_q   <= 2'd0;
         rp_q   <= 2'd0;
         for (int i = 0; i < 3; i++) buf_q[i] <= '0;
      end else begin
         occ_q  <= occ_d;
         infl_q <= fifo_en;
         wp_q   <= wp_d;
         rp_q   <= rp_d;
         // Read data arrives the cycle after fifo_en; it always lands in the buffer (no bypass).
         if (infl_q) begin
            case (wp_q)
               2'd0:    buf_q[0] <= fifo_dout;
               2'd1:    buf_q[1] <= fifo_dout;
               default: buf_q[2] <= fifo_dout;
            endcase
         end
      end
   end

endmodule
